// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises rx, samples mid-bit on the 16x tick, strobes each byte.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_deframer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state, state_next;
  logic                 sync_1, rx_s;
  logic [TW-1:0]        tick_cnt, tick_next;
  logic [BW-1:0]        bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 armed, armed_next;
  logic [DATA_BITS-1:0] data_next;
  logic                 done_next, ferr_next;
`ifdef UART_RX_PARITY_EN
  logic                 par_flag, par_flag_next, perr_next;
`endif

  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    shift_next = shift;
    armed_next = armed;
    data_next  = rx_data;
    done_next  = 1'b0;
    ferr_next  = frame_err;
`ifdef UART_RX_PARITY_EN
    par_flag_next = par_flag;
    perr_next     = parity_err;
`endif
    case (state)
      IDLE: begin
        tick_next = '0;
        // Only a high-to-low transition starts a frame, so a held-low break yields one frame.
        if (armed && !rx_s) begin
          state_next = START;
          armed_next = 1'b0;
        end else if (rx_s) begin
          armed_next = 1'b1;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_cnt == TICK_MID) begin
            tick_next  = '0;
            bit_next   = '0;
            state_next = rx_s ? IDLE : DATA;
          end else begin
            tick_next = tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          tick_next = tick_cnt + TW'(1);
          if (tick_cnt == TICK_END) begin
            shift_next = {rx_s, shift[DATA_BITS-1:1]};
            bit_next   = bit_cnt + BW'(1);
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          tick_next = tick_cnt + TW'(1);
          if (tick_cnt == TICK_END) begin
            par_flag_next = rx_s ^ (^shift);
            state_next    = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          tick_next = tick_cnt + TW'(1);
          if (tick_cnt == TICK_END) begin
            data_next  = shift;
            ferr_next  = ~rx_s;
            done_next  = 1'b1;
            state_next = IDLE;
            // A high stop bit arms the receiver so a start bit right behind it is caught.
            armed_next = rx_s;
`ifdef UART_RX_PARITY_EN
            perr_next  = par_flag;
`endif
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_1    <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      armed     <= 1'b0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_1    <= rx;
      rx_s      <= sync_1;
      state     <= state_next;
      tick_cnt  <= tick_next;
      bit_cnt   <= bit_next;
      shift     <= shift_next;
      armed     <= armed_next;
      rx_data   <= data_next;
      rx_done   <= done_next;
      frame_err <= ferr_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      par_flag   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_flag   <= par_flag_next;
      parity_err <= perr_next;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomised self-checking bench for uart_rx_deframer; s_tick every 4 clk, 64 clk per bit.
// Expected results come from each driven frame: byte, stop-bit level and parity-bit correctness.
module tb_uart_rx_deframer;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, frame_err, parity_err, busy;

  int checks = 0;
  int errors = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  logic [7:0] last_data = 8'h00;
  logic       prev_done = 1'b0;

  uart_rx_deframer #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx),
    .rx_data(rx_data), .rx_done(rx_done), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    int phase;
    phase = 0;
    forever begin
      @(negedge clk);
      s_tick = (phase == 3);
      phase = (phase + 1) % 4;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Record every strobe; a strobe must be single-cycle and land in IDLE.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rx_done) begin
        check_eq("done_single", prev_done, 1'b0);
        check_eq("busy_at_done", busy, 1'b0);
        got_q.push_back({parity_err, frame_err, rx_data});
      end
      prev_done = rx_done;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    hold(bits * BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    logic perr_exp;
    perr_exp = 1'b0;
    rx = 1'b0;
    hold(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold(BIT_CLK);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ !par_ok;
    hold(BIT_CLK);
    perr_exp = !par_ok;
`endif
    rx = stop_ok;
    hold(BIT_CLK);
    exp_q.push_back({perr_exp, !stop_ok, d});
  endtask

  task automatic drain();
    logic [9:0] g, e;
    check_eq("frame_count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check_eq("rx_data", g[7:0], e[7:0]);
      check_eq("frame_err", g[8], e[8]);
      check_eq("parity_err", g[9], e[9]);
      last_data = e[7:0];
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rx_done"}, rx_done, 1'b0);
    check_eq({tag, "_rx_data"}, rx_data, 8'h00);
    check_eq({tag, "_frame_err"}, frame_err, 1'b0);
    check_eq({tag, "_parity_err"}, parity_err, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    bit         stop_ok, par_ok;
    int         gap;

    hold(4);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    idle(2);

    // Good frame.
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(2);
    drain();

    // Glitch shorter than half a bit: no frame, data untouched.
    rx = 1'b0;
    hold(12);
    idle(3);
    drain();
    check_eq("glitch_rx_data", rx_data, last_data);
    check_eq("glitch_busy", busy, 1'b0);

    // Bad stop bit, then a good frame clears frame_err.
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(2);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(2);
    drain();

    // Back-to-back frames with no idle gap.
    send_frame(8'h14, 1'b1, 1'b1);
    send_frame(8'h28, 1'b1, 1'b1);
    idle(2);
    drain();

    // Break: line low for three frame times gives a single all-zero framing-error frame.
    rx = 1'b0;
    hold(30 * BIT_CLK);
    idle(2);
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    drain();

    // Reset midway through data bit 4; trailing bits stay high so no new start edge appears.
    d = 8'hF0 | 8'($urandom_range(0, 15));
    rx = 1'b0;
    hold(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      hold(BIT_CLK);
    end
    rx = 1'b1;
    hold(BIT_CLK / 2);
    check_eq("midframe_busy", busy, 1'b1);
    reset_n = 1'b0;
    hold(2);
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    idle(6);
    drain();
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(2);
    drain();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h14, 1'b1, 1'b1);
    idle(1);
    send_frame(8'h14, 1'b1, 1'b0);
    idle(2);
    drain();
`endif

    // Random frames: random bytes, occasional bad stop/parity, random gaps.
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
      par_ok = ($urandom_range(0, 5) != 0);
      gap = stop_ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
      send_frame(d, stop_ok, par_ok);
      idle(gap);
    end
    idle(2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Serial receive front end of the UART: synchronises the asynchronous `rx` line, detects start bits, samples each data bit at mid-bit using the shared 16x baud tick, and presents each completed byte with a one-cycle strobe. It sits directly upstream of the RX FIFO. `rx_done` drives the FIFO write enable and `rx_data` drives its write data, which the host then drains through `rd_en`/`data_out`.

## Interface
- `DATA_BITS`, 8: data bits per frame, sent LSB first.
- `OVERSAMPLE`, 16: `s_tick` pulses per bit period. Must be a power of two, ≥ 8.
- `clk` input 1: system clock. All logic is on the rising edge.
- `reset_n` input 1: reset, synchronous and active-low.
- `s_tick` input 1: baud oversample enable from the baud generator. One `clk` wide, `OVERSAMPLE` pulses per bit.
- `rx` input 1: asynchronous serial line, idle high.
- `rx_data` output DATA_BITS: last received byte. Held until the next `rx_done`.
- `rx_done` output 1: one-cycle strobe that a frame ended. Connects to the RX FIFO `wr_en`.
- `frame_err` output 1: the stop bit of the frame flagged by `rx_done` was sampled low. Valid with `rx_done` and held until the next `rx_done`.
- `parity_err` output 1: parity mismatch, with the same timing as `frame_err`. Constant 0 without the macro.
- `busy` output 1: high in every state except IDLE.

## Operation
- **Synchroniser:** two-flop synchroniser on `rx`, with both flops reset to 1. `rx_s` denotes the second flop.
- **Tick counter:** `tick_cnt` is log2(OVERSAMPLE) bits wide. It advances only on cycles where `s_tick` is high and wraps modulo OVERSAMPLE.
- **Bit counter:** `bit_cnt` is log2(DATA_BITS)+1 bits wide.
- **States:** IDLE, START, DATA, PARITY (only with the macro), STOP.
- **IDLE:**
  - Tracks `armed`, which is set once `rx_s` has been seen high.
  - `armed` and `rx_s`=0 → START, `tick_cnt`=0, `armed` cleared.
  - `armed` is set again on any later cycle with `rx_s`=1.
  - A line stuck low (break) therefore produces exactly one frame.
- **START:** on the `s_tick` where `tick_cnt`=OVERSAMPLE/2−1 (mid start bit):
  - `rx_s`=0 → DATA, `tick_cnt`=0, `bit_cnt`=0.
  - `rx_s`=1 → false start: IDLE, no strobe, no output change.
- **DATA:** on the `s_tick` where `tick_cnt`=OVERSAMPLE−1:
  - Shift `rx_s` into the MSB of the shift register (right shift), so data arrives LSB first.
  - Increment `bit_cnt`.
  - After DATA_BITS samples → PARITY, or → STOP without the macro.
- **PARITY:** at mid-bit, sample the parity bit. Even parity: expected value is the XOR of the data bits.
- **STOP:** at mid-bit:
  - Load `rx_data` from the shift register.
  - `frame_err` = ~`rx_s`.
  - `parity_err` = mismatch flag.
  - Pulse `rx_done`.
  - → IDLE.
- **Frame errors:** a frame with a bad stop bit or bad parity still strobes `rx_done`. The FIFO stores the byte, and the error flags qualify it.
- **`s_tick` outside START/DATA/PARITY/STOP:** ignored.
- **Reset values:** `reset_n`=0 on any edge, including mid-frame, gives:
  - state IDLE, counters 0, shift register 0, `armed` 0;
  - `rx_data`=0, `rx_done`=0, `frame_err`=0, `parity_err`=0, `busy`=0;
  - synchroniser flops = 1.
  - A frame in progress at reset is discarded, and the receiver re-arms only after it sees `rx` high.

## Timing
- `rx` to `rx_s`: 2 `clk` of latency.
- IDLE to START: takes the edge after `rx_s` falls, with `busy` high from that edge.
- `rx_done`: high for exactly the one `clk` cycle following the edge that registers the mid-stop `s_tick`. It is never asserted two cycles in a row.
- `rx_data`, `frame_err`, `parity_err`: update on the same edge that raises `rx_done`.
- Back-to-back frames: a start bit immediately after the stop bit must be caught.
  - The FSM is back in IDLE half a bit before the stop bit ends.
  - `armed` is already set because the stop bit is high.
- Frame length from the start-bit falling edge to `rx_done`: (DATA_BITS+1)·OVERSAMPLE + OVERSAMPLE/2 ticks, plus synchroniser and FSM latency. The parity bit adds OVERSAMPLE ticks.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - the PARITY state exists;
  - the frame is start + DATA_BITS + even-parity bit + stop;
  - `parity_err` is computed as described above.
- Undefined:
  - no PARITY state and no parity logic;
  - the frame is start + DATA_BITS + stop;
  - `parity_err` is tied to 0.

## Test plan
All scenarios use `s_tick` every 4 `clk`, so one bit period is 64 `clk`.
- **Good frame:** drive frame 0xA5 with a good stop bit → exactly one `rx_done` pulse, `rx_data`=0xA5, `frame_err`=0, `busy` low one cycle after the pulse.
- **Glitch:** `rx` low for 3 ticks, then high → no `rx_done`, `rx_data` unchanged, return to IDLE.
- **Bad stop bit:** frame 0x3C with stop bit low, then line high → `rx_done`, `rx_data`=0x3C, `frame_err`=1. A following good frame 0x01 clears `frame_err` to 0.
- **Back-to-back and break:**
  - frames 0x14 then 0x28 with no idle gap → two pulses with `rx_data` 0x14 then 0x28;
  - `rx` held low for 3 frame times → exactly one `rx_done`, with `rx_data`=0x00 and `frame_err`=1.
- **Reset mid-frame:** `reset_n`=0 for 2 `clk` midway through data bit 4, then a clean frame 0x5A → no strobe for the aborted frame, all outputs 0 during reset, then `rx_data`=0x5A.
- **Parity (macro defined):**
  - 0x14 with parity bit 0 → `parity_err`=0;
  - 0x14 with parity bit 1 → `parity_err`=1, `rx_done` still pulses.
